truth_table_checker: RTL and testbench

Hardware response checker that exhaustively sweeps a 4-input combinational unit under test, drives a, b, c, d through all 16 input combinations and samples its single output f. It compares every sample against a 16-bit expected truth table and reports pass/fail, the mismatch count, the first failing vector and the full observed table. It sits beside any 4-input/1-output combinational block in the lab designs as an on-chip self-test, in place of a simulation-only stimulus bench.

---
 rtl/truth_table_checker_if.sv | 31 +++
 rtl/truth_table_checker.sv | 128 ++++++++++++
 tb/tb_truth_table_checker.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// Signal bundle between the truth-table checker and whoever launches it.
// The checker side (slave) receives the run request, the expected table and
// the unit-under-test output; it drives the test vector and the run results.
interface truth_table_checker_if;
    logic        start;
    logic [15:0] exp_table;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic        fail_valid;
    logic [3:0]  first_fail;
    logic [15:0] obs_table;

    // Launcher / environment side.
    modport master (
        output start, exp_table, f_in,
        input  a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail, obs_table
    );

    // Checker side.
    modport slave (
        input  start, exp_table, f_in,
        output a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail, obs_table
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive response checker for a 4-input / 1-output combinational block.
// Steps {a,b,c,d} through vectors 0..15, holds each for SETTLE+1 cycles,
// samples f_in in the last cycle and compares it with a latched expected
// truth table. Reports pass/fail, mismatch count, first failing vector and
// the complete observed table.
module truth_table_checker #(
    parameter int unsigned SETTLE = 1    // settle cycles per vector, 1..15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  vec_q;
    logic [3:0]  cnt_q;
    logic [15:0] exp_q;
    logic [15:0] obs_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  err_q;
    logic        fail_valid_q;
    logic [3:0]  first_fail_q;

    logic        mismatch;
    logic [4:0]  err_d;

    // Comparison of the current sample and the error count it produces; only
    // used in the sampling state. Max count is 16, so 5 bits never overflow.
    assign mismatch = (bus.f_in != exp_q[vec_q]);
    assign err_d    = err_q + 5'(mismatch);

    // Sweep FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched table and observed table are ordinary flops and
            // are cleared here too, so an aborted run leaves no partial results.
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            exp_q        <= '0;
            obs_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q      <= ST_SETTLE;
                        exp_q        <= bus.exp_table;
                        vec_q        <= '0;
                        cnt_q        <= '0;
                        obs_q        <= '0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    obs_q[vec_q] <= bus.f_in;
                    err_q        <= err_d;
                    if (mismatch && !fail_valid_q) begin
                        first_fail_q <= vec_q;
                        fail_valid_q <= 1'b1;
                    end
                    if (vec_q == 4'hf) begin
                        // Last vector: drop the drive back to 0 and publish
                        // the verdict together with the done pulse.
                        state_q <= ST_DONE;
                        vec_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 5'd0);
                    end else begin
                        state_q <= ST_SETTLE;
                        vec_q   <= vec_q + 4'd1;
                        cnt_q   <= '0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a          = vec_q[3];
    assign bus.b          = vec_q[2];
    assign bus.c          = vec_q[1];
    assign bus.d          = vec_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;
    assign bus.obs_table  = obs_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=3), each
// driving a table-defined unit under test. A cycle-count model per instance
// predicts every output and is compared on each falling edge; directed runs
// add hand-computed expectations.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Stimulus per instance; uut_tab[j] bit i is the unit's f for vector i.
    logic        start_in [2];
    logic [15:0] exp_in   [2];
    logic [15:0] uut_tab  [2];

    always #5 clk = ~clk;

    truth_table_checker_if if0 ();
    truth_table_checker_if if1 ();

    truth_table_checker #(.SETTLE(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    truth_table_checker #(.SETTLE(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.start     = start_in[0];
    assign if0.exp_table = exp_in[0];
    assign if0.f_in      = uut_tab[0][{if0.a, if0.b, if0.c, if0.d}];
    assign if1.start     = start_in[1];
    assign if1.exp_table = exp_in[1];
    assign if1.f_in      = uut_tab[1][{if1.a, if1.b, if1.c, if1.d}];

    // Observed DUT outputs gathered per instance.
    logic [3:0]  d_vec  [2];
    logic        d_busy [2];
    logic        d_done [2];
    logic        d_pass [2];
    logic [4:0]  d_err  [2];
    logic        d_fv   [2];
    logic [3:0]  d_ff   [2];
    logic [15:0] d_obs  [2];

    assign d_vec[0]  = {if0.a, if0.b, if0.c, if0.d};
    assign d_busy[0] = if0.busy;
    assign d_done[0] = if0.done;
    assign d_pass[0] = if0.pass;
    assign d_err[0]  = if0.err_count;
    assign d_fv[0]   = if0.fail_valid;
    assign d_ff[0]   = if0.first_fail;
    assign d_obs[0]  = if0.obs_table;
    assign d_vec[1]  = {if1.a, if1.b, if1.c, if1.d};
    assign d_busy[1] = if1.busy;
    assign d_done[1] = if1.done;
    assign d_pass[1] = if1.pass;
    assign d_err[1]  = if1.err_count;
    assign d_fv[1]   = if1.fail_valid;
    assign d_ff[1]   = if1.first_fail;
    assign d_obs[1]  = if1.obs_table;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is a count k of edges since the accepted start. Vector
    // k/PER is on the pins while k < 16*PER; vector v is judged at k=(v+1)*PER;
    // done is the cycle k == 16*PER; idle again at k == 16*PER+1.
    for (genvar j = 0; j < 2; j++) begin : g_unit
        localparam int PER   = (j == 0) ? 2 : 4;
        localparam int TOTAL = 16 * PER;

        int          k_q;
        bit          run_q;
        logic [15:0] mexp_q;
        logic [15:0] mobs_q;
        int          merr_q;
        bit          mfv_q;
        int          mff_q;
        bit          mpass_q;
        bit          mbusy_q;
        bit          mdone_q;
        logic [3:0]  mvec;

        assign mvec = (run_q && k_q < TOTAL) ? 4'(k_q / PER) : 4'd0;

        always @(posedge clk or negedge rst_n) begin : step
            int          k;
            int          v;
            int          err;
            int          ff;
            bit          fv;
            logic        f;
            logic [15:0] obs;
            if (!rst_n) begin
                k_q <= 0; run_q <= 1'b0; mexp_q <= '0; mobs_q <= '0; merr_q <= 0;
                mfv_q <= 1'b0; mff_q <= 0; mpass_q <= 1'b0; mbusy_q <= 1'b0; mdone_q <= 1'b0;
            end else if (!run_q) begin
                if (start_in[j]) begin
                    run_q <= 1'b1; k_q <= 0; mexp_q <= exp_in[j]; mobs_q <= '0; merr_q <= 0;
                    mfv_q <= 1'b0; mff_q <= 0; mpass_q <= 1'b0; mbusy_q <= 1'b1; mdone_q <= 1'b0;
                end
            end else begin
                k   = k_q + 1;
                obs = mobs_q;
                err = merr_q;
                fv  = mfv_q;
                ff  = mff_q;
                if (k % PER == 0 && k <= TOTAL) begin
                    v      = k / PER - 1;
                    f      = uut_tab[j][v];
                    obs[v] = f;
                    if (f != mexp_q[v]) begin
                        err++;
                        if (!fv) begin
                            fv = 1'b1;
                            ff = v;
                        end
                    end
                end
                k_q    <= k;
                mobs_q <= obs;
                merr_q <= err;
                mfv_q  <= fv;
                mff_q  <= ff;
                if (k == TOTAL) begin
                    mbusy_q <= 1'b0;
                    mdone_q <= 1'b1;
                    mpass_q <= (err == 0);
                end else if (k == TOTAL + 1) begin
                    mdone_q <= 1'b0;
                    run_q   <= 1'b0;
                end
            end
        end

        // Compare every output against the model away from the active edge.
        always @(negedge clk) begin
            if (cmp_en) begin
                check($sformatf("u%0d vec", j),        32'(d_vec[j]),  32'(mvec));
                check($sformatf("u%0d busy", j),       32'(d_busy[j]), 32'(mbusy_q));
                check($sformatf("u%0d done", j),       32'(d_done[j]), 32'(mdone_q));
                check($sformatf("u%0d pass", j),       32'(d_pass[j]), 32'(mpass_q));
                check($sformatf("u%0d err_count", j),  32'(d_err[j]),  32'(merr_q));
                check($sformatf("u%0d fail_valid", j), 32'(d_fv[j]),   32'(mfv_q));
                check($sformatf("u%0d first_fail", j), 32'(d_ff[j]),   32'(mff_q));
                check($sformatf("u%0d obs_table", j),  32'(d_obs[j]),  32'(mobs_q));
            end
        end
    end

    task automatic pulse_start(input int j, input logic [15:0] e, input logic [15:0] u);
        @(negedge clk);
        uut_tab[j]  = u;
        exp_in[j]   = e;
        start_in[j] = 1'b1;
        @(negedge clk);
        start_in[j] = 1'b0;
    endtask

    // Counts rising edges until done is seen, starting just after edge 0.
    task automatic wait_done(input int j, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!d_done[j] && n < limit);
        check($sformatf("u%0d done seen", j), 32'(d_done[j]), 32'd1);
    endtask

    task automatic check_results(input string tag, input int j, input logic pass,
                                 input int err, input logic fv, input int ff,
                                 input logic [15:0] obs);
        check({tag, " pass"},       32'(d_pass[j]), 32'(pass));
        check({tag, " err_count"},  32'(d_err[j]),  32'(err));
        check({tag, " fail_valid"}, 32'(d_fv[j]),   32'(fv));
        if (fv) check({tag, " first_fail"}, 32'(d_ff[j]), 32'(ff));
        check({tag, " obs_table"},  32'(d_obs[j]),  32'(obs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int done_at;
        int done_cnt;
        start_in = '{1'b0, 1'b0};
        exp_in   = '{16'h0, 16'h0};
        uut_tab  = '{16'h0, 16'h0};

        // Reset and release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst busy0", 32'(d_busy[0]), 32'd0);
        check("rst vec0",  32'(d_vec[0]),  32'd0);
        check("rst busy1", 32'(d_busy[1]), 32'd0);

        // Pass run: unit is a^b^c^d, table 6996, SETTLE=1.
        pulse_start(0, 16'h6996, 16'h6996);
        wait_done(0, 100, n);
        check("xor done cycle", 32'(n), 32'd32);
        check_results("xor", 0, 1'b1, 0, 1'b0, 0, 16'h6996);
        @(posedge clk);
        #1;
        check("xor done width", 32'(d_done[0]), 32'd0);

        // Fail run: f tied 0.
        pulse_start(0, 16'h6996, 16'h0000);
        wait_done(0, 100, n);
        check_results("zero", 0, 1'b0, 8, 1'b1, 1, 16'h0000);
        @(posedge clk);

        // Vector order and timing with SETTLE=3.
        pulse_start(1, 16'h6996, 16'h6996);
        check("s3 vec at start", 32'(d_vec[1]), 32'd0);
        done_at  = 0;
        done_cnt = 0;
        for (int e = 1; e <= 72; e++) begin
            @(posedge clk);
            #1;
            if (e % 4 == 0 && e < 64) check($sformatf("s3 vec edge %0d", e), 32'(d_vec[1]), 32'(e / 4));
            if (d_done[1]) begin
                done_cnt++;
                if (done_at == 0) done_at = e;
            end
        end
        check("s3 done cycle", 32'(done_at), 32'd64);
        check("s3 done width", 32'(done_cnt), 32'd1);
        check_results("s3", 1, 1'b1, 0, 1'b0, 0, 16'h6996);

        // Start while busy plus table change mid-run: ignored.
        pulse_start(0, 16'h6990, 16'h6996);
        repeat (9) @(negedge clk);
        exp_in[0]   = 16'hffff;
        start_in[0] = 1'b1;
        @(negedge clk);
        start_in[0] = 1'b0;
        wait_done(0, 100, n);
        check("busy start done cycle", 32'(n), 32'd22);
        check_results("latched", 0, 1'b0, 2, 1'b1, 1, 16'h6996);
        @(posedge clk);

        // Repeat with start held high: relaunches right after DONE.
        @(negedge clk);
        exp_in[0]   = 16'h6990;
        start_in[0] = 1'b1;
        @(negedge clk);
        wait_done(0, 100, n);
        check("repeat done cycle", 32'(n), 32'd32);
        check_results("repeat", 0, 1'b0, 2, 1'b1, 1, 16'h6996);
        @(posedge clk);
        #1;
        check("held idle busy", 32'(d_busy[0]), 32'd0);
        @(posedge clk);
        #1;
        check("held relaunch busy", 32'(d_busy[0]), 32'd1);
        check("held relaunch cleared", 32'(d_err[0]), 32'd0);
        @(negedge clk);
        start_in[0] = 1'b0;
        wait_done(0, 100, n);
        check("relaunch done cycle", 32'(n), 32'd32);
        check_results("relaunch", 0, 1'b0, 2, 1'b1, 1, 16'h6996);
        @(posedge clk);

        // Reset at vector 7 on the SETTLE=3 instance.
        pulse_start(1, 16'h6996, 16'h00ff);
        repeat (28) @(posedge clk);
        #1;
        check("abort vec", 32'(d_vec[1]), 32'd7);
        check("abort err before", 32'(d_err[1]), 32'd4);
        check("abort obs before", 32'(d_obs[1]), 32'h007f);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy",  32'(d_busy[1]), 32'd0);
        check("abort err",   32'(d_err[1]),  32'd0);
        check("abort obs",   32'(d_obs[1]),  32'd0);
        check("abort fv",    32'(d_fv[1]),   32'd0);
        check("abort vec0",  32'(d_vec[1]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(1, 16'h6996, 16'h6996);
        wait_done(1, 200, n);
        check("after abort done cycle", 32'(n), 32'd64);
        check_results("after abort", 1, 1'b1, 0, 1'b0, 0, 16'h6996);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
